sdp_wdma_intr_tracker: RTL and testbench



---
 rtl/sdp_wdma_intr_tracker_if.sv | 34 +++
 rtl/sdp_wdma_intr_tracker.sv | 109 ++++++++++
 tb/tb_sdp_wdma_intr_tracker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sdp_wdma_intr_tracker_if.sv
// ---------------------------------------------------------------------------
// sdp_wdma_intr_tracker_if
//   Groups the signals between the SDP WDMA data stage, the MCIF/CVIF write
//   response paths and the GLB interrupt controller.
//   master : the environment (drives requests/completions, sees interrupts)
//   slave  : the tracker (consumes requests/completions, drives interrupts)
//   Signals:
//     intr_req_pvld / intr_req_ptr / intr_req_ram_type : layer-done request
//     mcif2sdp_wr_rsp_complete / cvif2sdp_wr_rsp_complete : write acks
//     sdp2glb_done_intr_pd : one-hot done pulse toward GLB
//     intr_idle / intr_ovf_err : status
// ---------------------------------------------------------------------------
interface sdp_wdma_intr_tracker_if;
    logic       intr_req_pvld;
    logic       intr_req_ptr;
    logic       intr_req_ram_type;
    logic       mcif2sdp_wr_rsp_complete;
    logic       cvif2sdp_wr_rsp_complete;
    logic [1:0] sdp2glb_done_intr_pd;
    logic       intr_idle;
    logic       intr_ovf_err;

    modport master (
        output intr_req_pvld, intr_req_ptr, intr_req_ram_type,
               mcif2sdp_wr_rsp_complete, cvif2sdp_wr_rsp_complete,
        input  sdp2glb_done_intr_pd, intr_idle, intr_ovf_err
    );

    modport slave (
        input  intr_req_pvld, intr_req_ptr, intr_req_ram_type,
               mcif2sdp_wr_rsp_complete, cvif2sdp_wr_rsp_complete,
        output sdp2glb_done_intr_pd, intr_idle, intr_ovf_err
    );
endinterface

// File: rtl/sdp_wdma_intr_tracker.sv
// ---------------------------------------------------------------------------
// sdp_wdma_intr_tracker
//   Holds SDP WDMA layer-done interrupt requests in order and releases each
//   one to GLB only after its memory interface (MCIF or CVIF) has reported a
//   completed write. Completions that arrive early are banked in per-interface
//   counters and consumed when the matching request reaches the FIFO head.
//   Ports:
//     nvdla_core_clk  : core clock
//     nvdla_core_rstn : asynchronous active-low reset
//     intr_if         : request/completion inputs, done pulse and status
// ---------------------------------------------------------------------------
module sdp_wdma_intr_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    sdp_wdma_intr_tracker_if.slave  intr_if
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              fifo_ptr_q [DEPTH];
    logic              fifo_ram_q [DEPTH];
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]  cv_cnt_q, cv_cnt_d;
    logic [1:0]        pd_q, pd_d;
    logic              ovf_q, ovf_d;

    logic empty, full, push, pop, head_ptr, head_ram;
    logic mc_inc, mc_dec, mc_sat, cv_inc, cv_dec, cv_sat;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == FULL_CNT);
        head_ptr = fifo_ptr_q[rd_q];
        head_ram = fifo_ram_q[rd_q];

        // Full is judged on registered state: a request arriving while full
        // is dropped even if the head pops in the same cycle.
        push = intr_if.intr_req_pvld && !full;
        pop  = !empty && (head_ram ? (mc_cnt_q != '0) : (cv_cnt_q != '0));

        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (AW + 1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW + 1)'(1);

        mc_inc = intr_if.mcif2sdp_wr_rsp_complete;
        mc_dec = pop && head_ram;
        mc_sat = mc_inc && !mc_dec && (mc_cnt_q == CNT_MAX);
        mc_cnt_d = mc_cnt_q;
        if (mc_inc && !mc_dec && !mc_sat)
            mc_cnt_d = mc_cnt_q + CNT_W'(1);
        else if (mc_dec && !mc_inc)
            mc_cnt_d = mc_cnt_q - CNT_W'(1);

        cv_inc = intr_if.cvif2sdp_wr_rsp_complete;
        cv_dec = pop && !head_ram;
        cv_sat = cv_inc && !cv_dec && (cv_cnt_q == CNT_MAX);
        cv_cnt_d = cv_cnt_q;
        if (cv_inc && !cv_dec && !cv_sat)
            cv_cnt_d = cv_cnt_q + CNT_W'(1);
        else if (cv_dec && !cv_inc)
            cv_cnt_d = cv_cnt_q - CNT_W'(1);

        ovf_d = ovf_q || (intr_if.intr_req_pvld && full) || mc_sat || cv_sat;
        pd_d  = pop ? (head_ptr ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ptr_q[i] <= 1'b0;
                fifo_ram_q[i] <= 1'b0;
            end
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            mc_cnt_q <= '0;
            cv_cnt_q <= '0;
            pd_q     <= 2'b00;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_ptr_q[wr_q] <= intr_if.intr_req_ptr;
                fifo_ram_q[wr_q] <= intr_if.intr_req_ram_type;
            end
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            mc_cnt_q <= mc_cnt_d;
            cv_cnt_q <= cv_cnt_d;
            pd_q     <= pd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign intr_if.sdp2glb_done_intr_pd = pd_q;
    assign intr_if.intr_idle            = empty && (mc_cnt_q == '0) && (cv_cnt_q == '0);
    assign intr_if.intr_ovf_err         = ovf_q;
endmodule

// File: tb/tb_sdp_wdma_intr_tracker.sv
module tb_sdp_wdma_intr_tracker;
    logic nvdla_core_clk  = 1'b0;
    logic nvdla_core_rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sdp_wdma_intr_tracker_if intr_if ();

    sdp_wdma_intr_tracker #(.DEPTH(4), .CNT_W(3)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .intr_if         (intr_if.slave)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic pv, input logic pt, input logic rm,
                       input logic mc, input logic cv);
        intr_if.intr_req_pvld            = pv;
        intr_if.intr_req_ptr             = pt;
        intr_if.intr_req_ram_type        = rm;
        intr_if.mcif2sdp_wr_rsp_complete = mc;
        intr_if.cvif2sdp_wr_rsp_complete = cv;
        @(posedge nvdla_core_clk);
        #1;
        intr_if.intr_req_pvld            = 1'b0;
        intr_if.intr_req_ptr             = 1'b0;
        intr_if.intr_req_ram_type        = 1'b0;
        intr_if.mcif2sdp_wr_rsp_complete = 1'b0;
        intr_if.cvif2sdp_wr_rsp_complete = 1'b0;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 nvdla_core_rstn = 1'b0;
        repeat (2) @(posedge nvdla_core_clk);
        #1 nvdla_core_rstn = 1'b1;
    endtask

    initial begin
        intr_if.intr_req_pvld            = 1'b0;
        intr_if.intr_req_ptr             = 1'b0;
        intr_if.intr_req_ram_type        = 1'b0;
        intr_if.mcif2sdp_wr_rsp_complete = 1'b0;
        intr_if.cvif2sdp_wr_rsp_complete = 1'b0;
        repeat (3) @(posedge nvdla_core_clk);
        #1;
        chk("rst_pd",   32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        chk("rst_idle", 32'(intr_if.intr_idle), 32'h1);
        chk("rst_ovf",  32'(intr_if.intr_ovf_err), 32'h0);
        nvdla_core_rstn = 1'b1;
        idle_cyc();

        // Basic: MC request, completion ten cycles later, pulse two after.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("basic_busy", 32'(intr_if.intr_idle), 32'h0);
        for (int i = 0; i < 9; i++) begin
            chk("basic_quiet", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
            idle_cyc();
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_c1", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        idle_cyc();
        chk("basic_pd",   32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        chk("basic_idle", 32'(intr_if.intr_idle), 32'h1);
        idle_cyc();
        chk("basic_once", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);

        // Ordering: MC head blocks a younger CV entry whose ack already came.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("ord_blocked", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
            idle_cyc();
        end
        chk("ord_cv_banked", 32'(dut.cv_cnt_q), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ord_c16", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        idle_cyc();
        chk("ord_first",  32'(intr_if.sdp2glb_done_intr_pd), 32'h2);
        idle_cyc();
        chk("ord_second", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        idle_cyc();
        chk("ord_done", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        chk("ord_idle", 32'(intr_if.intr_idle), 32'h1);

        // Early completions banked before their requests.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("early_bank", 32'(dut.cv_cnt_q), 32'h2);
        chk("early_nopd", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        repeat (5) idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("early_lat1", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("early_pd1", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        idle_cyc();
        chk("early_pd2", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        idle_cyc();
        chk("early_end", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        chk("early_cv0", 32'(dut.cv_cnt_q), 32'h0);
        chk("early_idle", 32'(intr_if.intr_idle), 32'h1);

        // Simultaneous push+pop and inc+dec.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim_mc1", 32'(dut.mc_cnt_q), 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sim_pd",  32'(intr_if.sdp2glb_done_intr_pd), 32'h2);
        chk("sim_mc",  32'(dut.mc_cnt_q), 32'h1);
        chk("sim_cnt", 32'(dut.cnt_q), 32'h1);
        idle_cyc();
        chk("sim_pd2",  32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        chk("sim_idle", 32'(intr_if.intr_idle), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("both_mc", 32'(dut.mc_cnt_q), 32'h1);
        chk("both_cv", 32'(dut.cv_cnt_q), 32'h1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("both_pd1", 32'(intr_if.sdp2glb_done_intr_pd), 32'h2);
        idle_cyc();
        chk("both_pd2", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        idle_cyc();
        chk("both_idle", 32'(intr_if.intr_idle), 32'h1);
        chk("both_ovf", 32'(intr_if.intr_ovf_err), 32'h0);

        // FIFO overflow: fifth request dropped, four pulses follow.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'(i), 1'b1, 1'b0, 1'b0);
        chk("ovf_pre", 32'(intr_if.intr_ovf_err), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(intr_if.intr_ovf_err), 32'h1);
        chk("ovf_cnt", 32'(dut.cnt_q), 32'h4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_p0", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_p1", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_p2", 32'(intr_if.sdp2glb_done_intr_pd), 32'h2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_p3", 32'(intr_if.sdp2glb_done_intr_pd), 32'h1);
        idle_cyc();
        chk("ovf_p4", 32'(intr_if.sdp2glb_done_intr_pd), 32'h2);
        idle_cyc();
        chk("ovf_p5", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        chk("ovf_idle",   32'(intr_if.intr_idle), 32'h1);
        chk("ovf_sticky", 32'(intr_if.intr_ovf_err), 32'h1);

        // Counter saturation after a clean reset.
        do_reset();
        chk("sat_clr", 32'(intr_if.intr_ovf_err), 32'h0);
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_mc7", 32'(dut.mc_cnt_q), 32'h7);
        chk("sat_pre", 32'(intr_if.intr_ovf_err), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_hold", 32'(dut.mc_cnt_q), 32'h7);
        chk("sat_err",  32'(intr_if.intr_ovf_err), 32'h1);

        // Asynchronous reset with pending entries and banked completions.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_pending", 32'(dut.cnt_q), 32'h3);
        #2 nvdla_core_rstn = 1'b0;
        #1;
        chk("mid_pd",   32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
        chk("mid_idle", 32'(intr_if.intr_idle), 32'h1);
        chk("mid_ovf",  32'(intr_if.intr_ovf_err), 32'h0);
        chk("mid_mc",   32'(dut.mc_cnt_q), 32'h0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_nopd", 32'(intr_if.sdp2glb_done_intr_pd), 32'h0);
            idle_cyc();
        end
        chk("mid_cv2", 32'(dut.cv_cnt_q), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
